// File: rtl/sseg_capture.sv
// Rebuilds 8-digit BCD frames from the active-low seven-segment bus. Optional blank digit: SSEG_CAPTURE_BLANK_EN.
// A frame appears SETTLE+2 edges after the last digit; it is held on frameValid until frameAck, and unacked completions set overrun.
module sseg_capture #(
   parameter int SETTLE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  SSeg,
   input  logic [7:0]  an,
   output logic [31:0] digits,
   output logic [7:0]  digErr,
   output logic        frameValid,
   input  logic        frameAck,
   output logic        overrun
);

   localparam int CW = $clog2(SETTLE + 1);

   typedef enum logic [1:0] {WAIT, SETTLING, SAMPLED} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic          take;
   logic [7:0]    anR;
   logic [6:0]    segR;
   logic [31:0]   shadow;
   logic [7:0]    shadowErr;
   logic [7:0]    seen;
   logic          in_valid;
   logic          pair_chg;
   logic          frame_done;
   logic [2:0]    idx;
   logic [3:0]    dec_val;
   logic          dec_err;

   // State and count describe the pair being loaded into anR/segR, so the
   // count already covers the first registered cycle of a new dwell.
   assign in_valid   = $onehot(~an);
   assign pair_chg   = (an != anR) || (SSeg != segR);
   assign frame_done = (seen == 8'hFF);

   always_comb begin
      if (pair_chg)
         cnt_nx = CW'(1);
      else if (cnt == CW'(SETTLE))
         cnt_nx = cnt;
      else
         cnt_nx = cnt + CW'(1);
   end

   always_comb begin
      idx = 3'd0;
      for (int i = 0; i < 8; i++)
         if (!anR[i]) idx = 3'(i);
   end

   always_comb begin
      dec_val = 4'hF;
      dec_err = 1'b1;
      case (segR)
         7'b1000000: begin dec_val = 4'd0; dec_err = 1'b0; end
         7'b1111001: begin dec_val = 4'd1; dec_err = 1'b0; end
         7'b0100100: begin dec_val = 4'd2; dec_err = 1'b0; end
         7'b0110000: begin dec_val = 4'd3; dec_err = 1'b0; end
         7'b0011001: begin dec_val = 4'd4; dec_err = 1'b0; end
         7'b0010010: begin dec_val = 4'd5; dec_err = 1'b0; end
         7'b0000010: begin dec_val = 4'd6; dec_err = 1'b0; end
         7'b1111000: begin dec_val = 4'd7; dec_err = 1'b0; end
         7'b0000000: begin dec_val = 4'd8; dec_err = 1'b0; end
         7'b0011000: begin dec_val = 4'd9; dec_err = 1'b0; end
`ifdef SSEG_CAPTURE_BLANK_EN
         7'b1111111: begin dec_val = 4'hA; dec_err = 1'b0; end
`endif
         default:    begin dec_val = 4'hF; dec_err = 1'b1; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= WAIT;
         cnt        <= '0;
         take       <= 1'b0;
         anR        <= 8'hFF;
         segR       <= 7'h7F;
         shadow     <= '0;
         shadowErr  <= '0;
         seen       <= '0;
         digits     <= '0;
         digErr     <= '0;
         frameValid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         anR  <= an;
         segR <= SSeg;
         take <= 1'b0;

         if (!in_valid) begin
            state <= WAIT;
            cnt   <= '0;
         end else begin
            cnt <= cnt_nx;
            if (pair_chg || state != SAMPLED) begin
               if (cnt_nx == CW'(SETTLE)) begin
                  state <= SAMPLED;
                  take  <= 1'b1;
               end else begin
                  state <= SETTLING;
               end
            end
         end

         // take is one cycle behind the count, when anR/segR still hold the settled pair
         if (take) begin
            shadow[{idx, 2'b00} +: 4] <= dec_val;
            shadowErr[idx]            <= dec_err;
         end
         seen <= (frame_done ? 8'h00 : seen) | (take ? (8'h01 << idx) : 8'h00);

         if (frame_done) begin
            if (!frameValid || frameAck) begin
               digits     <= shadow;
               digErr     <= shadowErr;
               frameValid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (frameValid && frameAck) begin
            frameValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sseg_capture.sv
// Directed bench for sseg_capture with SETTLE=4: scans, short dwells, illegal codes, overrun and reset.
module tb_sseg_capture;

   logic        clk;
   logic        rst;
   logic [6:0]  SSeg;
   logic [7:0]  an;
   logic [31:0] digits;
   logic [7:0]  digErr;
   logic        frameValid;
   logic        frameAck;
   logic        overrun;

   int n_checks = 0;
   int n_fail   = 0;

   sseg_capture #(.SETTLE(4)) dut (
      .clk(clk), .rst(rst), .SSeg(SSeg), .an(an),
      .digits(digits), .digErr(digErr), .frameValid(frameValid),
      .frameAck(frameAck), .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] segof(input logic [3:0] v);
      case (v)
         4'd0: segof = 7'b1000000;
         4'd1: segof = 7'b1111001;
         4'd2: segof = 7'b0100100;
         4'd3: segof = 7'b0110000;
         4'd4: segof = 7'b0011001;
         4'd5: segof = 7'b0010010;
         4'd6: segof = 7'b0000010;
         4'd7: segof = 7'b1111000;
         4'd8: segof = 7'b0000000;
         4'd9: segof = 7'b0011000;
         default: segof = 7'b1111111;
      endcase
   endfunction

   function automatic logic [7:0] anof(input int i);
      logic [7:0] m;
      m = 8'h01 << i;
      anof = ~m;
   endfunction

   task automatic hold(input logic [7:0] a, input logic [6:0] s, input int n);
      an   = a;
      SSeg = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic scan8(input logic [31:0] v);
      for (int i = 0; i < 8; i++) hold(anof(i), segof(v[4*i +: 4]), 6);
   endtask

   task automatic do_ack();
      frameAck = 1'b1;
      @(negedge clk);
      frameAck = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++; if (digits !== 32'h0) begin n_fail++; $display("FAIL reset_digits got %h want %h", digits, 32'h0); end
      n_checks++; if (digErr !== 8'h00) begin n_fail++; $display("FAIL reset_digerr got %h want %h", digErr, 8'h00); end
      n_checks++; if (frameValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", frameValid); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
      hold(8'hFF, 7'h40, 20);
      n_checks++; if (frameValid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b want 0", frameValid); end
      n_checks++; if (digits !== 32'h0) begin n_fail++; $display("FAIL idle_digits got %h want %h", digits, 32'h0); end
   endtask

   task automatic test_scan();
      for (int i = 0; i < 7; i++) hold(anof(i), segof(4'(i + 1)), 6);
      hold(anof(7), segof(4'd8), 5);
      n_checks++; if (frameValid !== 1'b0) begin n_fail++; $display("FAIL scan_early_valid got %b want 0", frameValid); end
      @(negedge clk);
      n_checks++; if (frameValid !== 1'b1) begin n_fail++; $display("FAIL scan_valid got %b want 1", frameValid); end
      n_checks++; if (digits !== 32'h87654321) begin n_fail++; $display("FAIL scan_digits got %h want %h", digits, 32'h87654321); end
      n_checks++; if (digErr !== 8'h00) begin n_fail++; $display("FAIL scan_digerr got %h want %h", digErr, 8'h00); end
      an = 8'hFF;
      do_ack();
      n_checks++; if (frameValid !== 1'b0) begin n_fail++; $display("FAIL scan_ack_valid got %b want 0", frameValid); end
   endtask

   task automatic test_short_dwell();
      for (int i = 0; i < 8; i++)
         if (i == 3) hold(anof(3), segof(4'd7), 3);
         else        hold(anof(i), segof(4'(i + 1)), 6);
      hold(8'hFF, 7'h7F, 8);
      n_checks++; if (frameValid !== 1'b0) begin n_fail++; $display("FAIL short_no_frame got %b want 0", frameValid); end
      hold(anof(3), 7'b0011001, 6);
      hold(8'hFF, 7'h7F, 2);
      n_checks++; if (frameValid !== 1'b1) begin n_fail++; $display("FAIL short_fill_valid got %b want 1", frameValid); end
      n_checks++; if (digits !== 32'h87654321) begin n_fail++; $display("FAIL short_fill_digits got %h want %h", digits, 32'h87654321); end
      do_ack();
   endtask

   task automatic test_bad_code();
      logic [31:0] exp_d;
      logic [7:0]  exp_e;
`ifdef SSEG_CAPTURE_BLANK_EN
      exp_d = 32'h00F00A00;
      exp_e = 8'h20;
`else
      exp_d = 32'h00F00F00;
      exp_e = 8'h24;
`endif
      for (int i = 0; i < 8; i++)
         if (i == 5)      hold(anof(i), 7'b0101010, 6);
         else if (i == 2) hold(anof(i), 7'b1111111, 6);
         else             hold(anof(i), segof(4'd0), 6);
      hold(8'hFF, 7'h7F, 2);
      n_checks++; if (frameValid !== 1'b1) begin n_fail++; $display("FAIL bad_valid got %b want 1", frameValid); end
      n_checks++; if (digits !== exp_d) begin n_fail++; $display("FAIL bad_digits got %h want %h", digits, exp_d); end
      n_checks++; if (digErr !== exp_e) begin n_fail++; $display("FAIL bad_digerr got %h want %h", digErr, exp_e); end
      do_ack();
   endtask

   task automatic test_back_to_back();
      scan8(32'h87654321);
      n_checks++; if (frameValid !== 1'b1) begin n_fail++; $display("FAIL b2b_a_valid got %b want 1", frameValid); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_a_overrun got %b want 0", overrun); end
      scan8(32'h99999999);
      n_checks++; if (digits !== 32'h87654321) begin n_fail++; $display("FAIL b2b_held_digits got %h want %h", digits, 32'h87654321); end
      n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun got %b want 1", overrun); end
      n_checks++; if (frameValid !== 1'b1) begin n_fail++; $display("FAIL b2b_b_valid got %b want 1", frameValid); end
      for (int i = 0; i < 7; i++) hold(anof(i), segof(4'(i)), 6);
      hold(anof(7), segof(4'd7), 5);
      frameAck = 1'b1;
      @(negedge clk);
      frameAck = 1'b0;
      n_checks++; if (frameValid !== 1'b1) begin n_fail++; $display("FAIL b2b_c_valid got %b want 1", frameValid); end
      n_checks++; if (digits !== 32'h76543210) begin n_fail++; $display("FAIL b2b_c_digits got %h want %h", digits, 32'h76543210); end
      hold(8'hFF, 7'h7F, 1);
      n_checks++; if (frameValid !== 1'b1) begin n_fail++; $display("FAIL b2b_c_stays got %b want 1", frameValid); end
      n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_sticky got %b want 1", overrun); end
      do_ack();
      n_checks++; if (frameValid !== 1'b0) begin n_fail++; $display("FAIL b2b_ack got %b want 0", frameValid); end
   endtask

   task automatic test_invalid_and_reset();
      for (int i = 0; i < 8; i++)
         if (i != 3) hold(anof(i), segof(4'd5), 6);
      hold(8'b11110011, segof(4'd2), 10);
      hold(8'hFF, 7'h7F, 4);
      n_checks++; if (frameValid !== 1'b0) begin n_fail++; $display("FAIL twozero_no_frame got %b want 0", frameValid); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun got %b want 0", overrun); end
      n_checks++; if (digits !== 32'h0) begin n_fail++; $display("FAIL rst_digits got %h want %h", digits, 32'h0); end
      hold(anof(7), segof(4'd2), 6);
      hold(8'hFF, 7'h7F, 4);
      n_checks++; if (frameValid !== 1'b0) begin n_fail++; $display("FAIL rst_mask_cleared got %b want 0", frameValid); end
      scan8(32'h23456789);
      n_checks++; if (frameValid !== 1'b1) begin n_fail++; $display("FAIL post_rst_valid got %b want 1", frameValid); end
      n_checks++; if (digits !== 32'h23456789) begin n_fail++; $display("FAIL post_rst_digits got %h want %h", digits, 32'h23456789); end
      n_checks++; if (digErr !== 8'h00) begin n_fail++; $display("FAIL post_rst_digerr got %h want %h", digErr, 8'h00); end
   endtask

   initial begin
      rst      = 1'b1;
      an       = 8'hFF;
      SSeg     = 7'h7F;
      frameAck = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_scan();
      test_short_dwell();
      test_bad_code();
      test_back_to_back();
      test_invalid_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
